comp_alu_pipe: RTL and testbench



---
 rtl/comp_alu_pipe.sv | 170 +++++++++++++++++
 tb/tb_comp_alu_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/comp_alu_pipe.sv
// Two-stage pipelined R-type execute unit: RF read into S1, ALU + write-back into S2.
// Optional multiplier (funct 011000) enabled by defining COMP_ALU_PIPE_MUL_EN.
module comp_alu_pipe #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              cfg_we,
    input  logic [4:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero,
    output logic              out_carry,
    output logic              out_illegal
);
    localparam int AW = (REG_NUM > 2) ? $clog2(REG_NUM) : 1;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_MUL = 6'b011000;

    logic [DATA_W-1:0] rf [REG_NUM];

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [4:0]        s1_rd;
    logic [4:0]        s1_shamt;
    logic [5:0]        s1_funct;
    logic              s1_illegal;

    logic              advance;
    logic              accept;
    logic              fwd_ok;
    logic              wb_en;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [DATA_W-1:0] rs_rf;
    logic [DATA_W-1:0] rt_rf;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [DATA_W:0]   sum;
`ifdef COMP_ALU_PIPE_MUL_EN
    logic [2*DATA_W-1:0] prod;
`endif

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL: return 1'b1;
`ifdef COMP_ALU_PIPE_MUL_EN
            F_MUL: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    assign advance  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || advance;
    assign accept   = in_valid && in_ready;
    assign rs       = in_instr[25:21];
    assign rt       = in_instr[20:16];

    // Only a result that will really land in the RF may be forwarded.
    assign fwd_ok = advance && !s1_illegal && (s1_rd != 5'd0) && (int'(s1_rd) < REG_NUM);
    assign wb_en  = fwd_ok;

    always_comb begin
        rs_rf = '0;
        rt_rf = '0;
        if (rs != 5'd0 && int'(rs) < REG_NUM) rs_rf = rf[rs[AW-1:0]];
        if (rt != 5'd0 && int'(rt) < REG_NUM) rt_rf = rf[rt[AW-1:0]];
        rs_val = (fwd_ok && rs == s1_rd) ? alu_res : rs_rf;
        rt_val = (fwd_ok && rt == s1_rd) ? alu_res : rt_rf;
    end

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        sum       = '0;
`ifdef COMP_ALU_PIPE_MUL_EN
        prod      = '0;
`endif
        case (s1_funct)
            F_ADD: begin
                sum       = {1'b0, s1_a} + {1'b0, s1_b};
                alu_res   = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
            end
            F_SUB: begin
                sum       = {1'b0, s1_a} + {1'b0, ~s1_b} + {{DATA_W{1'b0}}, 1'b1};
                alu_res   = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
            end
            F_AND: alu_res = s1_a & s1_b;
            F_OR:  alu_res = s1_a | s1_b;
            F_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            F_SLL: alu_res = (int'(s1_shamt) >= DATA_W) ? '0 : (s1_b << s1_shamt);
            F_SRL: alu_res = (int'(s1_shamt) >= DATA_W) ? '0 : (s1_b >> s1_shamt);
`ifdef COMP_ALU_PIPE_MUL_EN
            F_MUL: begin
                prod      = {{DATA_W{1'b0}}, s1_a} * {{DATA_W{1'b0}}, s1_b};
                alu_res   = prod[DATA_W-1:0];
                alu_carry = |prod[2*DATA_W-1:DATA_W];
            end
`endif
            default: ;
        endcase
        if (s1_illegal) begin
            alu_res   = '0;
            alu_carry = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_rd       <= '0;
            s1_shamt    <= '0;
            s1_funct    <= '0;
            s1_illegal  <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_zero    <= 1'b0;
            out_carry   <= 1'b0;
            out_illegal <= 1'b0;
            for (int i = 0; i < REG_NUM; i++) rf[i] <= '0;
        end else begin
            if (accept) begin
                s1_valid   <= 1'b1;
                s1_a       <= rs_val;
                s1_b       <= rt_val;
                s1_rd      <= in_instr[15:11];
                s1_shamt   <= in_instr[10:6];
                s1_funct   <= in_instr[5:0];
                s1_illegal <= (in_instr[31:26] != 6'd0) || !funct_legal(in_instr[5:0]);
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            if (advance) begin
                out_valid   <= 1'b1;
                out_data    <= alu_res;
                out_zero    <= (alu_res == '0);
                out_carry   <= alu_carry;
                out_illegal <= s1_illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Write-back is issued after cfg so it wins a same-address collision.
            if (cfg_we && int'(cfg_addr) < REG_NUM) rf[cfg_addr[AW-1:0]] <= cfg_data;
            if (wb_en) rf[s1_rd[AW-1:0]] <= alu_res;
        end
    end
endmodule

// File: tb/tb_comp_alu_pipe.sv
// Directed bench for comp_alu_pipe: hand-computed vectors, a negedge result monitor and one check task.
module tb_comp_alu_pipe;
    localparam int DATA_W = 32;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_MUL = 6'b011000;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              cfg_we;
    logic [4:0]        cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_zero;
    logic              out_carry;
    logic              out_illegal;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] q[$];

    comp_alu_pipe #(.DATA_W(DATA_W), .REG_NUM(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_carry(out_carry), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic [DATA_W-1:0] d, input logic z, c, ill);
        logic [63:0] r;
        r = '0;
        r[DATA_W-1:0] = d;
        r[DATA_W]     = z;
        r[DATA_W+1]   = c;
        r[DATA_W+2]   = ill;
        return r;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                                       input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    // A transfer happens at the next rising edge whenever both are high here.
    always @(negedge clk)
        if (out_valid && out_ready) q.push_back(pk(out_data, out_zero, out_carry, out_illegal));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [4:0] a, input logic [DATA_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [31:0] ins);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("send_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [63:0] exp);
        int n;
        logic [63:0] got;
        n = 0;
        while (q.size() == 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        got = (q.size() > 0) ? q.pop_front() : '1;
        check(tag, got, exp);
    endtask

    task automatic rd_reg(input string tag, input logic [4:0] r, input logic [DATA_W-1:0] v);
        send(mk(6'd0, r, 5'd0, 5'd0, 5'd0, F_OR));
        get_result(tag, pk(v, v == '0, 1'b0, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {28'd0, out_valid, out_illegal, out_carry, out_zero, out_data}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;

        // Basic add and latency
        cfg(5'd1, 32'd5);
        cfg(5'd2, 32'd3);
        send(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, F_ADD));
        check("lat_s1", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        check("lat_s2", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'd8});
        get_result("add", pk(32'd8, 1'b0, 1'b0, 1'b0));
        rd_reg("r3", 5'd3, 32'd8);

        // Carry / borrow and logic ops
        cfg(5'd1, 32'hFFFF_FFFF);
        cfg(5'd2, 32'd1);
        send(mk(6'd0, 5'd1, 5'd2, 5'd4, 5'd0, F_ADD));
        get_result("add_carry", pk(32'd0, 1'b1, 1'b1, 1'b0));
        send(mk(6'd0, 5'd2, 5'd1, 5'd5, 5'd0, F_SUB));
        get_result("sub_borrow", pk(32'd2, 1'b0, 1'b0, 1'b0));
        send(mk(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, F_SUB));
        get_result("sub_noborrow", pk(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0));
        send(mk(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, F_AND));
        get_result("and", pk(32'd1, 1'b0, 1'b0, 1'b0));
        send(mk(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, F_OR));
        get_result("or", pk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
        send(mk(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, F_SLT));
        get_result("slt_true", pk(32'd1, 1'b0, 1'b0, 1'b0));
        send(mk(6'd0, 5'd2, 5'd1, 5'd6, 5'd0, F_SLT));
        get_result("slt_false", pk(32'd0, 1'b1, 1'b0, 1'b0));
        send(mk(6'd0, 5'd0, 5'd2, 5'd6, 5'd31, F_SLL));
        get_result("sll31", pk(32'h8000_0000, 1'b0, 1'b0, 1'b0));
        send(mk(6'd0, 5'd0, 5'd1, 5'd6, 5'd28, F_SRL));
        get_result("srl28", pk(32'h0000_000F, 1'b0, 1'b0, 1'b0));

        // Back-to-back dependencies through the bypass
        cfg(5'd1, 32'd5);
        cfg(5'd2, 32'd3);
        cfg(5'd3, 32'h77);
        cfg(5'd5, 32'h100);
        send(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, F_ADD));
        send(mk(6'd0, 5'd3, 5'd2, 5'd4, 5'd0, F_SUB));
        get_result("byp_add", pk(32'd8, 1'b0, 1'b0, 1'b0));
        get_result("byp_rs", pk(32'd5, 1'b0, 1'b1, 1'b0));
        rd_reg("r4", 5'd4, 32'd5);
        rd_reg("r3b", 5'd3, 32'd8);
        send(mk(6'd0, 5'd1, 5'd2, 5'd5, 5'd0, F_ADD));
        send(mk(6'd0, 5'd1, 5'd5, 5'd6, 5'd0, F_SUB));
        get_result("byp_add2", pk(32'd8, 1'b0, 1'b0, 1'b0));
        get_result("byp_rt", pk(32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0));
        send(mk(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, F_ADD));
        send(mk(6'd0, 5'd0, 5'd0, 5'd12, 5'd0, F_OR));
        get_result("rd0_result", pk(32'd8, 1'b0, 1'b0, 1'b0));
        get_result("rd0_nobyp", pk(32'd0, 1'b1, 1'b0, 1'b0));
        rd_reg("r0", 5'd0, 32'd0);

        // Backpressure: two accepted, third stalls, outputs held
        out_ready = 1'b0;
        send(mk(6'd0, 5'd1, 5'd2, 5'd7, 5'd0, F_ADD));
        send(mk(6'd0, 5'd1, 5'd2, 5'd8, 5'd0, F_SUB));
        check("bp_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1;
        in_instr = mk(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, F_OR);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {30'd0, in_ready, out_valid, out_data}, {30'd0, 1'b0, 1'b1, 32'd8});
        end
        check("bp_nodrain", 64'(q.size()), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        get_result("bp_first", pk(32'd8, 1'b0, 1'b0, 1'b0));
        get_result("bp_second", pk(32'd2, 1'b0, 1'b1, 1'b0));
        get_result("bp_third", pk(32'd7, 1'b0, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("bp_nodup", 64'(q.size()), 64'd0);
        rd_reg("r9", 5'd9, 32'd7);

        // Illegal instructions leave the target untouched
        cfg(5'd10, 32'h55);
        send(mk(6'd1, 5'd1, 5'd2, 5'd10, 5'd0, F_ADD));
        get_result("ill_op", pk(32'd0, 1'b1, 1'b0, 1'b1));
        send(mk(6'd0, 5'd1, 5'd2, 5'd10, 5'd0, 6'b111111));
        get_result("ill_funct", pk(32'd0, 1'b1, 1'b0, 1'b1));
        rd_reg("r10", 5'd10, 32'h55);
        send(mk(6'd0, 5'd1, 5'd2, 5'd11, 5'd0, F_MUL));
`ifdef COMP_ALU_PIPE_MUL_EN
        get_result("mult", pk(32'd15, 1'b0, 1'b0, 1'b0));
`else
        get_result("mult_ill", pk(32'd0, 1'b1, 1'b0, 1'b1));
`endif

        // cfg and write-back to the same register on the same edge
        send(mk(6'd0, 5'd1, 5'd2, 5'd13, 5'd0, F_ADD));
        cfg(5'd13, 32'hAA);
        get_result("coll_res", pk(32'd8, 1'b0, 1'b0, 1'b0));
        rd_reg("r13", 5'd13, 32'd8);

        // Reset with both stages full
        out_ready = 1'b0;
        send(mk(6'd0, 5'd1, 5'd2, 5'd14, 5'd0, F_ADD));
        send(mk(6'd0, 5'd1, 5'd2, 5'd15, 5'd0, F_ADD));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("flush_out", {62'd0, out_valid, in_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_empty", 64'(q.size()), 64'd0);
        rd_reg("r1_clr", 5'd1, 32'd0);
        rd_reg("r14_clr", 5'd14, 32'd0);
        rd_reg("r15_clr", 5'd15, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
